// File: rtl/call_dispatcher_if.sv
// Call-register and direction-request bundle between input processor, dispatcher and car FSM.
// No storage: wiring only. The master side drives the calls and strobes, the slave side drives the requests and clears.
// No backpressure: every signal is either a level or a one-cycle strobe.
interface call_dispatcher_if #(
  parameter int N_FLOORS = 8,
  parameter int FW       = 3
);
  logic [N_FLOORS-1:0] up_call;
  logic [N_FLOORS-1:0] down_call;
  logic [N_FLOORS-1:0] floor_btn;
  logic [FW-1:0]       floor;
  logic                arrive;
  logic                door_done;
  logic                nextup;
  logic                nextdown;
  logic                open_req;
  logic [N_FLOORS-1:0] clr_up;
  logic [N_FLOORS-1:0] clr_down;
  logic [N_FLOORS-1:0] clr_btn;
  logic [1:0]          dir_state;

  modport master (
    output up_call, down_call, floor_btn, floor, arrive, door_done,
    input  nextup, nextdown, open_req, clr_up, clr_down, clr_btn, dir_state
  );

  modport slave (
    input  up_call, down_call, floor_btn, floor, arrive, door_done,
    output nextup, nextdown, open_req, clr_up, clr_down, clr_btn, dir_state
  );
endinterface

// File: rtl/call_dispatcher.sv
// Picks the travel direction from pending hall/car calls and acknowledges served floors.
// Latency: every output is registered, one clk after the causing input.
// No backpressure: calls are level inputs and the clears are one-cycle pulses.
module call_dispatcher #(
  parameter int N_FLOORS     = 8,
  parameter int FW           = 3,
  parameter int DOOR_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  call_dispatcher_if.slave bus
);
  localparam int TW = $clog2(DOOR_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GO_UP   = 2'b01,
    GO_DOWN = 2'b10,
    SERVE   = 2'b11
  } state_t;

  state_t              state, state_n;
  logic                dir_up, dir_up_n;
  logic [TW-1:0]       timer, timer_n;
  logic                entry;

  logic                nextup_q, nextdown_q, open_q;
  logic [N_FLOORS-1:0] clr_up_q, clr_down_q, clr_btn_q;
  logic [N_FLOORS-1:0] clr_up_n, clr_down_n, clr_btn_n;

  logic                floor_ok;
  logic [N_FLOORS-1:0] any_call, here_oh, above_mask, below_mask;
  logic [FW-1:0]       near_up, near_dn;
  logic                here, above, below, up_closer;
  logic                stop_up, stop_dn, serve_again;

  always_comb begin : decode
    floor_ok = 32'(bus.floor) < N_FLOORS;
    any_call = bus.up_call | bus.down_call | bus.floor_btn;
    near_up  = '0;
    near_dn  = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      here_oh[i]    = floor_ok && (FW'(i) == bus.floor);
      above_mask[i] = floor_ok && (FW'(i) >  bus.floor);
      below_mask[i] = floor_ok && (FW'(i) <  bus.floor);
    end
    // Lowest pending floor above and highest pending floor below the car.
    for (int i = N_FLOORS - 1; i >= 0; i--)
      if (any_call[i] && above_mask[i]) near_up = FW'(i);
    for (int i = 0; i < N_FLOORS; i++)
      if (any_call[i] && below_mask[i]) near_dn = FW'(i);
    here      = |(any_call & here_oh);
    above     = |(any_call & above_mask);
    below     = |(any_call & below_mask);
    up_closer = (near_up - bus.floor) <= (bus.floor - near_dn);
    stop_up   = |(here_oh & (bus.floor_btn | bus.up_call |
                             (bus.down_call & {N_FLOORS{~above}})));
    stop_dn   = |(here_oh & (bus.floor_btn | bus.down_call |
                             (bus.up_call & {N_FLOORS{~below}})));
    // Re-open only for calls the entry pulse would actually clear, so an
    // opposite-direction hall call left for later cannot pin the car in SERVE.
    serve_again = |(here_oh & (bus.floor_btn |
                               (bus.up_call   & {N_FLOORS{dir_up | ~below}}) |
                               (bus.down_call & {N_FLOORS{~dir_up | ~above}})));
  end

  always_comb begin : next_state
    state_n  = state;
    dir_up_n = dir_up;
    timer_n  = timer;
    entry    = 1'b0;
    if (floor_ok) begin
      case (state)
        IDLE: begin
          if (here) begin
            state_n  = SERVE;
            dir_up_n = 1'b1;
            entry    = 1'b1;
          end else if (above && below) begin
            state_n = up_closer ? GO_UP : GO_DOWN;
          end else if (above) begin
            state_n = GO_UP;
          end else if (below) begin
            state_n = GO_DOWN;
          end
        end
        GO_UP: begin
          if (bus.arrive) begin
            if (stop_up) begin
              state_n  = SERVE;
              dir_up_n = 1'b1;
              entry    = 1'b1;
            end else if (!above) begin
              state_n = IDLE;
            end
          end
        end
        GO_DOWN: begin
          if (bus.arrive) begin
            if (stop_dn) begin
              state_n  = SERVE;
              dir_up_n = 1'b0;
              entry    = 1'b1;
            end else if (!below) begin
              state_n = IDLE;
            end
          end
        end
        default: begin
          if (bus.door_done || timer == TW'(DOOR_TIMEOUT - 1)) begin
            timer_n = '0;
            if (serve_again) begin
              entry = 1'b1;
            end else if (dir_up ? above : below) begin
              state_n = dir_up ? GO_UP : GO_DOWN;
            end else if (dir_up ? below : above) begin
              state_n = dir_up ? GO_DOWN : GO_UP;
            end else begin
              state_n = IDLE;
            end
          end else begin
            timer_n = timer + 1'b1;
          end
        end
      endcase
    end
    // Hall clears follow the direction the car leaves in; a call facing the other way survives unless nothing lies that way.
    clr_btn_n  = entry ? here_oh : '0;
    clr_up_n   = (entry && (dir_up_n || !below))  ? here_oh : '0;
    clr_down_n = (entry && (!dir_up_n || !above)) ? here_oh : '0;
  end

  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      state  <= IDLE;
      dir_up <= 1'b1;
      timer  <= '0;
    end else begin
      state  <= state_n;
      dir_up <= dir_up_n;
      timer  <= timer_n;
    end
  end

  always_ff @(posedge clk) begin : out_reg
    if (rst) begin
      nextup_q   <= 1'b0;
      nextdown_q <= 1'b0;
      open_q     <= 1'b0;
      clr_up_q   <= '0;
      clr_down_q <= '0;
      clr_btn_q  <= '0;
    end else begin
      nextup_q   <= (state_n == GO_UP);
      nextdown_q <= (state_n == GO_DOWN);
      open_q     <= (state_n == SERVE);
      clr_up_q   <= clr_up_n;
      clr_down_q <= clr_down_n;
      clr_btn_q  <= clr_btn_n;
    end
  end

  assign bus.nextup    = nextup_q;
  assign bus.nextdown  = nextdown_q;
  assign bus.open_req  = open_q;
  assign bus.clr_up    = clr_up_q;
  assign bus.clr_down  = clr_down_q;
  assign bus.clr_btn   = clr_btn_q;
  assign bus.dir_state = state;
endmodule

// File: tb/tb_call_dispatcher.sv
// Scoreboard bench for call_dispatcher: a rule-level reference model predicts each cycle's outputs and a monitor compares them.
module tb_call_dispatcher;
  localparam int N   = 8;
  localparam int TMO = 64;
  localparam int ST_IDLE = 0, ST_UP = 1, ST_DN = 2, ST_SRV = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  call_dispatcher_if #(.N_FLOORS(N), .FW(3)) ifc ();

  call_dispatcher #(.N_FLOORS(N), .FW(3), .DOOR_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct packed {
    logic       nu;
    logic       nd;
    logic       op;
    logic [7:0] cu;
    logic [7:0] cd;
    logic [7:0] cb;
    logic [1:0] ds;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  int   cur_fl   = 0;
  int   m_st     = ST_IDLE;
  int   m_tm     = 0;
  bit   m_up     = 1'b1;

  // Reference model: applies the dispatch rules to this edge's inputs and queues the outputs expected after it.
  always @(posedge clk) begin : ref_model
    obs_t       e;
    int         f, du, dn, nst, ntm;
    bit         ab, be, nup, entry, arr, dd;
    logic [7:0] a, u, d, b, hb;
    e   = '0;
    u   = ifc.up_call;
    d   = ifc.down_call;
    b   = ifc.floor_btn;
    a   = u | d | b;
    f   = int'(ifc.floor);
    arr = ifc.arrive;
    dd  = ifc.door_done;
    du  = N;
    dn  = N;
    for (int i = 0; i < N; i++)
      if (a[i]) begin
        if (i > f && i - f < du) du = i - f;
        if (i < f && f - i < dn) dn = f - i;
      end
    ab = (du < N);
    be = (dn < N);
    hb = '0;
    hb[f] = 1'b1;
    nst   = m_st;
    nup   = m_up;
    ntm   = m_tm;
    entry = 1'b0;
    if (rst) begin
      nst = ST_IDLE;
      nup = 1'b1;
      ntm = 0;
    end else begin
      case (m_st)
        ST_IDLE:
          if (a[f]) begin nst = ST_SRV; nup = 1'b1; entry = 1'b1; end
          else if (ab && be) nst = (du <= dn) ? ST_UP : ST_DN;
          else if (ab) nst = ST_UP;
          else if (be) nst = ST_DN;
        ST_UP:
          if (arr) begin
            if (b[f] || u[f] || (d[f] && !ab)) begin nst = ST_SRV; nup = 1'b1; entry = 1'b1; end
            else if (!ab) nst = ST_IDLE;
          end
        ST_DN:
          if (arr) begin
            if (b[f] || d[f] || (u[f] && !be)) begin nst = ST_SRV; nup = 1'b0; entry = 1'b1; end
            else if (!be) nst = ST_IDLE;
          end
        default:
          if (dd || m_tm == TMO - 1) begin
            ntm = 0;
            if (b[f] || (u[f] && (m_up || !be)) || (d[f] && (!m_up || !ab))) entry = 1'b1;
            else if (m_up && ab)  nst = ST_UP;
            else if (!m_up && be) nst = ST_DN;
            else if (m_up && be)  nst = ST_DN;
            else if (!m_up && ab) nst = ST_UP;
            else nst = ST_IDLE;
          end else begin
            ntm = m_tm + 1;
          end
      endcase
      e.nu = (nst == ST_UP);
      e.nd = (nst == ST_DN);
      e.op = (nst == ST_SRV);
      e.ds = 2'(nst);
      if (entry) begin
        e.cb = hb;
        if (nup || !be) e.cu = hb;
        if (!nup || !ab) e.cd = hb;
      end
    end
    exp_q.push_back(e);
    m_st <= nst;
    m_up <= nup;
    m_tm <= ntm;
  end

  always @(posedge clk) begin : monitor
    obs_t act, e;
    #1;
    cycle++;
    act = {ifc.nextup, ifc.nextdown, ifc.open_req, ifc.clr_up, ifc.clr_down,
           ifc.clr_btn, ifc.dir_state};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL cyc%0d scoreboard_empty: actual %h, required a queued expectation", cycle, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        failures++;
        $display("FAIL cyc%0d outputs: actual nu=%b nd=%b open=%b clr_up=%b clr_dn=%b clr_btn=%b dir=%b, required nu=%b nd=%b open=%b clr_up=%b clr_dn=%b clr_btn=%b dir=%b",
                 cycle, act.nu, act.nd, act.op, act.cu, act.cd, act.cb, act.ds,
                 e.nu, e.nd, e.op, e.cu, e.cd, e.cb, e.ds);
      end
    end
  end

  // Input-processor stand-in: clears take effect, new presses win over them.
  task automatic apply(input logic r, input logic [7:0] pu, input logic [7:0] pd,
                       input logic [7:0] pb, input logic arr, input logic dd);
    rst           = r;
    ifc.up_call   = (ifc.up_call   & ~ifc.clr_up)   | pu;
    ifc.down_call = (ifc.down_call & ~ifc.clr_down) | pd;
    ifc.floor_btn = (ifc.floor_btn & ~ifc.clr_btn)  | pb;
    ifc.floor     = 3'(cur_fl);
    ifc.arrive    = arr;
    ifc.door_done = dd;
  endtask

  task automatic cyc(input logic r, input logic [7:0] pu, input logic [7:0] pd,
                     input logic [7:0] pb, input logic arr, input logic dd);
    @(negedge clk);
    apply(r, pu, pd, pb, arr, dd);
  endtask

  task automatic hold(input int n);
    repeat (n) cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic zap();
    ifc.up_call   = '0;
    ifc.down_call = '0;
    ifc.floor_btn = '0;
  endtask

  function automatic logic [7:0] rnd_press();
    logic [7:0] v;
    v = '0;
    if ($urandom_range(0, 11) == 0) v[$urandom_range(0, 7)] = 1'b1;
    return v;
  endfunction

  initial begin : stimulus
    logic [7:0] pu, pd, pb;
    logic       arr, dd, r, door_en;
    int         mv;
    rst = 1'b1;
    zap();
    ifc.floor     = '0;
    ifc.arrive    = 1'b0;
    ifc.door_done = 1'b0;

    // Reset, then idle with no calls.
    repeat (2) cyc(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    hold(5);

    // Car call from ground to floor 4, served and closed.
    cyc(1'b0, 8'h00, 8'h00, 8'h10, 1'b0, 1'b0);
    hold(3);
    cur_fl = 4; cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    hold(4);
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    hold(3);

    // Pass a down call on the way up, serve it on the way back.
    cur_fl = 2; cyc(1'b0, 8'h20, 8'h08, 8'h00, 1'b0, 1'b0);
    hold(2);
    cur_fl = 3; cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    hold(2);
    cur_fl = 4; cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    hold(1);
    cur_fl = 5; cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    hold(3);
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    hold(2);
    cur_fl = 4; cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    hold(1);
    cur_fl = 3; cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    hold(3);
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    hold(2);

    // Nearest-floor choice, reset while travelling down and up.
    cyc(1'b0, 8'h00, 8'h00, 8'h81, 1'b0, 1'b0);
    hold(2);
    cyc(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); zap();
    hold(2);
    cur_fl = 4; cyc(1'b0, 8'h00, 8'h00, 8'h81, 1'b0, 1'b0);
    hold(2);
    cyc(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); zap();
    hold(2);
    cyc(1'b0, 8'h40, 8'h00, 8'h04, 1'b0, 1'b0);
    hold(2);
    cur_fl = 5; cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    hold(1);
    cur_fl = 6; cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    hold(3);
    cyc(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); zap();
    hold(3);

    // Door timeout with a call pending above, then a timeout with nothing left.
    cur_fl = 1; cyc(1'b0, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0);
    hold(5);
    cyc(1'b0, 8'h00, 8'h00, 8'h40, 1'b0, 1'b0);
    hold(70);
    for (int fl = 2; fl <= 6; fl++) begin
      cur_fl = fl; cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
      hold(1);
    end
    hold(70);

    // Random traffic with a car model that follows nextup/nextdown.
    mv = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      pu  = rnd_press();
      pd  = rnd_press();
      pb  = rnd_press();
      arr = 1'b0;
      if (ifc.nextup && cur_fl < N - 1) begin
        if (mv == 0) begin cur_fl++; arr = 1'b1; mv = $urandom_range(0, 3); end
        else mv--;
      end else if (ifc.nextdown && cur_fl > 0) begin
        if (mv == 0) begin cur_fl--; arr = 1'b1; mv = $urandom_range(0, 3); end
        else mv--;
      end else if ($urandom_range(0, 29) == 0) begin
        arr = 1'b1;
      end
      door_en = (k % 600) >= 150;
      dd = door_en && ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 499) == 0);
      apply(r, pu, pd, pb, arr, dd);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
